// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline-boundary register with skid entry, stall hold, flush and stall counter
module pipe_stage_buf #(
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 3,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    logic              live_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic pop;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == TWO);

    // live_q keeps in_ready low while reset is held and for the edge that releases it
    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready = live_q & ~skid_valid & ~stall & ~flush;
        end else begin : g_pass
            assign in_ready = live_q & (~main_valid | out_ready) & ~stall & ~flush;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign pop    = main_valid & out_ready & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            live_q      <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (flush) begin
                // data registers intentionally keep their contents; only control is squashed
                state_q     <= EMPTY;
                main_ctrl_q <= '0;
                skid_ctrl_q <= '0;
            end else if (!stall) begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            main_ctrl_q <= in_ctrl;
                            main_data_q <= in_data;
                            state_q     <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            main_ctrl_q <= in_ctrl;
                            main_data_q <= in_data;
                        end else if (accept) begin
                            skid_ctrl_q <= in_ctrl;
                            skid_data_q <= in_data;
                            state_q     <= TWO;
                        end else if (pop) begin
                            state_q <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            main_ctrl_q <= skid_ctrl_q;
                            main_data_q <= skid_data_q;
                            state_q     <= ONE;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline-boundary register, the successor to the fixed per-stage latch registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a CTRL_W control bundle and a DATA_W data bundle with valid/ready handshaking and an optional skid entry, so producer ready no longer depends combinationally on downstream ready. It also has stall-hold, flush-to-bubble and a saturating stall-cycle counter, and is instantiated between any two pipeline stages.

Parameters:
DATA_W, 128, width of the data bundle (immediates, PC+4, results, rd address, concatenated).
CTRL_W, 3, width of the control bundle (reg write, writeback select and similar). Forced to 0 on bubbles.
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold request (e.g. D-cache miss): freeze all entries.
flush  in  1  squash: invalidate all entries.
in_valid  in  1  upstream has a beat.
in_ready  out  1  block can accept a beat this cycle.
in_ctrl  in  CTRL_W  upstream control bundle.
in_data  in  DATA_W  upstream data bundle.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream consumes the head this cycle.
out_ctrl  out  CTRL_W  head control; 0 when out_valid=0.
out_data  out  DATA_W  head data; holds its last value when invalid.
stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (rst_n=0, async):
  - main and skid entries invalid; ctrl and data registers cleared to 0; stall_cnt=0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=0 during reset.
  - After reset: in_ready=1 on the first clock edge.
  - Reset mid-transfer discards all entries.
- Handshake terms:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready & !stall & !flush.
  - Latency: one cycle from accept to out_valid when the block is empty.
- States (SKID_EN=1):
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - TWO: main and skid valid.
  - in_ready = !skid_valid & !stall & !flush. It is registered-derived only; there is no combinational path from out_ready.
- Transitions (no stall, no flush):
  - EMPTY + accept -> ONE; main <= in.
  - ONE + accept & pop -> ONE; main <= in.
  - ONE + accept & !pop -> TWO; skid <= in.
  - ONE + pop & !accept -> EMPTY.
  - TWO + pop -> ONE; main <= skid. No accept is possible in TWO.
  - Ordering is strictly FIFO; a beat is never duplicated or dropped.
- SKID_EN=0:
  - Single main entry.
  - in_ready = (!main_valid | out_ready) & !stall & !flush. This path is combinational from out_ready.
  - Same accept/pop rules as above.
- stall=1 (flush=0):
  - All entries, valids and outputs hold exactly their current values.
  - in_ready=0; no pop and no accept.
  - out_valid keeps its value; downstream must not commit while stall=1.
- flush=1:
  - On that edge, main_valid and skid_valid go to 0 and ctrl registers go to 0. Data registers hold.
  - Any in_valid beat that cycle is discarded (in_ready=0).
  - Flush dominates stall.
  - Block is EMPTY the next cycle.
- stall_cnt:
  - Increments by 1 on each edge with stall=1, independent of flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Widths: ctrl and data are copied bit-exact, with no arithmetic. out_ctrl is masked to 0 whenever out_valid=0.

Test Plan:
- Reset, then 4 back-to-back beats with data=0x11..0x44 and out_ready=1 -> outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, 1 cycle after each accept; in_ready stays 1.
- SKID_EN=1: accept 0xA1, drop out_ready for 3 cycles while in_valid=1 with 0xA2, 0xA3 -> 0xA2 lands in skid, in_ready=0 in TWO, 0xA3 is held upstream; release -> order 0xA1, 0xA2, 0xA3 with no loss or duplicate.
- Stall for 5 cycles with main valid (ctrl=3'b101, data=0x1234) -> out_valid, out_ctrl and out_data unchanged, in_ready=0, stall_cnt=5.
- Flush together with stall in state TWO -> next cycle out_valid=0, out_ctrl=0, state EMPTY, concurrent input beat discarded; stall_cnt still increments.
- Assert rst_n low asynchronously mid-cycle in state TWO -> outputs 0 immediately, before the next clock edge; stall_cnt=0.
- CNT_W=4 with stall held for 20 cycles -> stall_cnt saturates at 15. SKID_EN=0 with out_ready=0 and main valid -> in_ready=0 combinationally, rising to 1 in the same cycle out_ready rises.
